// File: rtl/pma_window_lookup_pkg.sv
// Shared widths, FSM encoding and payload types for the anchor-RAM window lookup engine.
package pma_window_lookup_pkg;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned REC_W  = 144;
    localparam int unsigned ID_W   = 12;
    localparam int unsigned ID_LSB = 132;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One entry of the read-tag pipe: which slot was issued and whether it held live data then.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              bit_q;
    } tag_t;

    function automatic logic [ID_W-1:0] rec_id(input logic [REC_W-1:0] rec);
        return rec[ID_LSB +: ID_W];
    endfunction

endpackage

// File: rtl/pma_window_lookup_valid_bitmap.sv
// Per-slot valid bits: set by snooped RAM writes, cleared by invalidates; a set beats a clear on the same slot.
module pma_window_lookup_valid_bitmap
    import pma_window_lookup_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit_c
);

    logic [DEPTH-1:0] bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= '0;
        end else begin
            if (clr_en) bits[clr_addr] <= 1'b0;
            if (set_en) bits[set_addr] <= 1'b1;
        end
    end

    assign rd_bit_c = bits[rd_addr];

endmodule

// File: rtl/pma_window_lookup.sv
// Sequential slot scan over the anchor RAM returning the lowest-index live record whose window id matches.
module pma_window_lookup
    import pma_window_lookup_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ID_W-1:0]   req_window_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_slot,
    output logic [REC_W-1:0]  rsp_record,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [REC_W-1:0]  ram_read_data,
    input  logic              snoop_wr_en,
    input  logic [ADDR_W-1:0] snoop_wr_addr,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr
);

    state_t          state;
    logic [ID_W-1:0] id_q;
    logic            issue_done;
    tag_t            tag;
    logic            bitmap_bit_c;
    logic            id_match_c;
    logic            hit_c;
    logic            last_c;

    pma_window_lookup_valid_bitmap u_bitmap (
        .clk      (clk),
        .rst      (rst),
        .set_en   (snoop_wr_en),
        .set_addr (snoop_wr_addr),
        .clr_en   (inv_en),
        .clr_addr (inv_addr),
        .rd_addr  (ram_read_addr),
        .rd_bit_c (bitmap_bit_c)
    );

    // Select on the valid bit so unwritten (X) RAM data can never leak into the hit decision.
    always_comb begin
        id_match_c = 1'b0;
        hit_c      = 1'b0;
        last_c     = 1'b0;
        id_match_c = (rec_id(ram_read_data) == id_q);
        hit_c      = (tag.valid && tag.bit_q) ? id_match_c : 1'b0;
        last_c     = tag.valid && (tag.addr == ADDR_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_slot      <= '0;
            rsp_record    <= '0;
            ram_read_addr <= '0;
            id_q          <= '0;
            issue_done    <= 1'b0;
            tag           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state         <= ST_SCAN;
                        req_ready     <= 1'b0;
                        id_q          <= req_window_id;
                        ram_read_addr <= '0;
                        issue_done    <= 1'b0;
                        tag           <= '0;
                    end
                end
                ST_SCAN: begin
                    // Issue side: one read per edge, tagging the slot and its pre-update valid bit.
                    if (!issue_done) begin
                        tag.valid <= 1'b1;
                        tag.addr  <= ram_read_addr;
                        tag.bit_q <= bitmap_bit_c;
                        if (ram_read_addr == ADDR_W'(DEPTH - 1)) begin
                            issue_done <= 1'b1;
                        end else begin
                            ram_read_addr <= ram_read_addr + ADDR_W'(1);
                        end
                    end else begin
                        tag.valid <= 1'b0;
                    end
                    // Compare side: first hit wins; the read still in flight is dropped.
                    if (hit_c) begin
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_hit    <= 1'b1;
                        rsp_slot   <= tag.addr;
                        rsp_record <= ram_read_data;
                    end else if (last_c) begin
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_hit    <= 1'b0;
                        rsp_slot   <= '0;
                        rsp_record <= '0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pma_window_lookup.sv
// Scoreboard bench for pma_window_lookup with a behavioural RAM and a lowest-matching-slot reference model.
module tb_pma_window_lookup;
    import pma_window_lookup_pkg::*;

    localparam int unsigned CW = 160;

    typedef struct {
        bit               hit;
        int               slot;
        logic [REC_W-1:0] rec;
        int               lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ID_W-1:0]   req_window_id = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_hit;
    logic [ADDR_W-1:0] rsp_slot;
    logic [REC_W-1:0]  rsp_record;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [REC_W-1:0]  ram_read_data;
    logic              snoop_en = 1'b0;
    logic              mem_we = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [REC_W-1:0]  wr_data = '0;
    logic              inv_en = 1'b0;
    logic [ADDR_W-1:0] inv_addr = '0;

    logic [REC_W-1:0]  mem [DEPTH];
    bit                vmodel [DEPTH];
    exp_t              exp_q [$];
    int                acc_q [$];
    int                edge_cnt = 0;
    int                ready_mode = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    bit                in_resp = 0;
    logic [150:0]      held;
    exp_t              mon_e;
    int                mon_lat;

    pma_window_lookup dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_window_id (req_window_id),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_slot      (rsp_slot),
        .rsp_record    (rsp_record),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data),
        .snoop_wr_en   (snoop_en),
        .snoop_wr_addr (wr_addr),
        .inv_en        (inv_en),
        .inv_addr      (inv_addr)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: a same-edge write returns the old word.
    always @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= wr_data;
        ram_read_data <= mem[ram_read_addr];
    end

    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (rst) acc_q.delete();
        else if (req_valid && req_ready) acc_q.push_back(edge_cnt);
    end

    always @(negedge clk) begin
        case (ready_mode)
            0:       rsp_ready = ($urandom_range(0, 2) == 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on each new response, then checks it holds until taken.
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 0;
        end else if (rsp_valid) begin
            if (!in_resp) begin
                in_resp = 1;
                held = {rsp_hit, rsp_slot, rsp_record};
                chk("rsp_hit_known", CW'($isunknown(rsp_hit)), CW'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", CW'(rsp_valid), CW'(0));
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_lat = (acc_q.size() != 0) ? edge_cnt - acc_q.pop_front() : -1;
                    chk("rsp_hit", CW'(rsp_hit), CW'(mon_e.hit));
                    chk("rsp_slot", CW'(rsp_slot), CW'(mon_e.slot));
                    chk("rsp_record", CW'(rsp_record), CW'(mon_e.rec));
                    chk("latency", CW'(mon_lat), CW'(mon_e.lat));
                end
            end else begin
                chk("rsp_hold_stable", CW'({rsp_hit, rsp_slot, rsp_record}), CW'(held));
                chk("req_ready_in_resp", CW'(req_ready), CW'(0));
            end
        end else if (in_resp) begin
            in_resp = 0;
            chk("req_ready_after_resp", CW'(req_ready), CW'(1));
        end
    end

    function automatic logic [REC_W-1:0] mkrec(input logic [ID_W-1:0] id);
        logic [REC_W-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        r[128 +: 4]      = 4'($urandom_range(0, 15));
        r[ID_LSB +: ID_W] = id;
        return r;
    endfunction

    task automatic write_rec(input int a, input logic [REC_W-1:0] d, input bit snoop);
        @(negedge clk);
        mem_we = 1'b1; snoop_en = snoop; wr_addr = ADDR_W'(a); wr_data = d;
        @(negedge clk);
        mem_we = 1'b0; snoop_en = 1'b0;
        if (snoop) vmodel[a] = 1;
    endtask

    task automatic invalidate(input int a);
        @(negedge clk);
        inv_en = 1'b1; inv_addr = ADDR_W'(a);
        @(negedge clk);
        inv_en = 1'b0;
        vmodel[a] = 0;
    endtask

    task automatic write_and_inv(input int a, input logic [REC_W-1:0] d);
        @(negedge clk);
        mem_we = 1'b1; snoop_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
        inv_en = 1'b1; inv_addr = ADDR_W'(a);
        @(negedge clk);
        mem_we = 1'b0; snoop_en = 1'b0; inv_en = 1'b0;
        vmodel[a] = 1;
    endtask

    // Reference: lowest live slot whose id field equals the request, taken from the RAM at accept time.
    task automatic lookup(input logic [ID_W-1:0] id);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        chk("req_ready_timeout", CW'(req_ready), CW'(1));
        e.hit = 0; e.slot = 0; e.rec = '0; e.lat = DEPTH + 1;
        for (int k = 0; k < DEPTH; k++) begin
            if (vmodel[k] && mem[k][ID_LSB +: ID_W] == id) begin
                e.hit = 1; e.slot = k; e.rec = mem[k]; e.lat = k + 2;
                break;
            end
        end
        exp_q.push_back(e);
        req_valid = 1'b1; req_window_id = id;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin @(negedge clk); n++; end
        chk("drain_timeout", CW'(n < 1000), CW'(1));
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", CW'(req_ready), CW'(1));
        chk("rst_rsp_valid", CW'(rsp_valid), CW'(0));
        chk("rst_rsp_hit", CW'(rsp_hit), CW'(0));
        chk("rst_rsp_slot", CW'(rsp_slot), CW'(0));
        chk("rst_rsp_record", CW'(rsp_record), CW'(0));
        chk("rst_ram_read_addr", CW'(ram_read_addr), CW'(0));
    endtask

    initial begin
        logic [ID_W-1:0] pool [4];
        logic [ID_W-1:0] junk_ids [4];
        int n;
        pool[0] = 12'h010; pool[1] = 12'h011; pool[2] = 12'h012; pool[3] = 12'h013;
        junk_ids[0] = 12'h042; junk_ids[1] = 12'h100; junk_ids[2] = 12'h7FF; junk_ids[3] = 12'h0AB;
        for (int k = 0; k < DEPTH; k++) vmodel[k] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // Stale data in every slot, never snooped, so it must stay invisible.
        for (int k = 0; k < DEPTH; k++) write_rec(k, mkrec(junk_ids[$urandom_range(0, 3)]), 0);

        write_rec(2, {12'h042, 132'h0}, 1);
        lookup(12'h042);
        wait_done();

        ready_mode = 1;
        lookup(12'h042);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_rsp_valid_timeout", CW'(rsp_valid), CW'(1));
        repeat (3) @(negedge clk);
        ready_mode = 2;
        wait_done();
        ready_mode = 0;

        lookup(12'h7FF);
        wait_done();

        write_rec(5, mkrec(12'h100), 1);
        write_rec(9, mkrec(12'h100), 1);
        lookup(12'h100);
        wait_done();

        invalidate(2);
        write_rec(3, mkrec(12'h042), 1);
        invalidate(3);
        lookup(12'h042);
        wait_done();
        write_and_inv(3, mkrec(12'h042));
        lookup(12'h042);
        wait_done();

        // Abort a scan part way through with reset.
        write_rec(40, mkrec(12'h0AB), 1);
        lookup(12'h0AB);
        n = 0;
        while (ram_read_addr != ADDR_W'(10) && n < 100) begin @(negedge clk); n++; end
        chk("scan_reach_10", CW'(ram_read_addr), CW'(10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) vmodel[k] = 0;
        check_reset_vals();
        repeat (2) @(negedge clk);
        chk("no_rsp_after_abort", CW'(rsp_valid), CW'(0));
        lookup(12'h0AB);
        wait_done();
        lookup(12'h100);
        wait_done();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: write_rec($urandom_range(0, DEPTH - 1), mkrec(pool[$urandom_range(0, 3)]), 1);
                4:          invalidate($urandom_range(0, DEPTH - 1));
                5:          write_and_inv($urandom_range(0, DEPTH - 1), mkrec(pool[$urandom_range(0, 3)]));
                6:          write_rec($urandom_range(0, DEPTH - 1), mkrec(pool[$urandom_range(0, 3)]), 0);
                default: begin
                    if ($urandom_range(0, 4) == 0) lookup(12'($urandom));
                    else lookup(pool[$urandom_range(0, 3)]);
                    wait_done();
                end
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            lookup(pool[i]);
            wait_done();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
